rx_capture_ctrl: RTL and testbench

//   Sequencer for the Ethernet RX debug capture path. Samples PHY1 receive byte

---
 rtl/rx_cap_pkg.sv | 20 ++
 rtl/rx_trig_detect.sv | 47 ++++
 rtl/rx_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_rx_capture_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cap_pkg.sv
// Shared definitions for the RX debug capture sequencer: FSM encoding,
// trigger mode codes and the Ethernet start-of-frame delimiter byte.
package rx_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

    localparam logic [1:0] TRIG_DV_RISE = 2'b00;
    localparam logic [1:0] TRIG_SFD     = 2'b01;
    localparam logic [1:0] TRIG_IMM     = 2'b10;
    localparam logic [1:0] TRIG_DV_ALT  = 2'b11;

    localparam logic [7:0] SFD_BYTE = 8'hD5;

endpackage

// File: rtl/rx_trig_detect.sv
// Trigger qualifier for the capture sequencer: dv rising edge, first SFD of a
// frame, or immediate. The sequencer decides when a hit is actually taken.
module rx_trig_detect
    import rx_cap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] trig_mode,
    input  logic       rx_dv,
    input  logic [7:0] rx_d,
    output logic       trig_hit
);

    logic dv_q;
    logic sfd_seen;
    logic sfd_byte;

    assign sfd_byte = rx_dv && (rx_d == SFD_BYTE);

    // sfd_seen limits SFD triggering to one hit per frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dv_q     <= 1'b0;
            sfd_seen <= 1'b0;
        end else begin
            dv_q <= rx_dv;
            if (!rx_dv) begin
                sfd_seen <= 1'b0;
            end else if (sfd_byte) begin
                sfd_seen <= 1'b1;
            end
        end
    end

    // Immediate mode always hits; the sequencer only listens in WAIT, so the
    // first WAIT cycle is the one that triggers.
    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TRIG_SFD:     trig_hit = sfd_byte && !sfd_seen;
            TRIG_IMM:     trig_hit = 1'b1;
            TRIG_DV_RISE: trig_hit = rx_dv && !dv_q;
            TRIG_DV_ALT:  trig_hit = rx_dv && !dv_q;
        endcase
    end

endmodule

// File: rtl/rx_capture_ctrl.sv
// RX debug capture sequencer: streams {rx_dv, rx_d} into a ring RAM, keeps
// PRE_DEPTH samples of history, then captures post_len samples after a trigger.
//
// state | meaning
// IDLE  | no writes, waiting for arm
// PRE   | filling the pre-trigger history, triggers ignored
// WAIT  | ring runs freely, waiting for a trigger
// POST  | writing post-trigger samples
// DONE  | frozen, trig/start addresses valid
module rx_capture_ctrl
    import rx_cap_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int PRE_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [ADDR_W-1:0] post_len_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_d_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [8:0]        wr_data_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic [ADDR_W-1:0] start_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int              POST_MAX_I = (1 << ADDR_W) - PRE_DEPTH - 1;
    localparam int              PRE_LAST_I = PRE_DEPTH - 1;
    localparam logic [ADDR_W-1:0] POST_MAX = POST_MAX_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PRE_LAST = PRE_LAST_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PRE_OFF  = PRE_DEPTH[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    cap_state_t        state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] post_len;
    logic              wr_now;
    logic              arm_take;
    logic              trig_take;
    logic              trig_hit;

    rx_trig_detect u_trig (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .trig_mode (trig_mode_i),
        .rx_dv     (rx_dv_i),
        .rx_d      (rx_d_i),
        .trig_hit  (trig_hit)
    );

    always_comb begin
        state_nx  = state;
        wr_now    = 1'b0;
        arm_take  = 1'b0;
        trig_take = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm_i) begin
                    arm_take = 1'b1;
                    state_nx = ST_PRE;
                end
            end
            ST_PRE: begin
                wr_now = 1'b1;
                if (pre_cnt == '0) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                wr_now = 1'b1;
                if (trig_hit) begin
                    trig_take = 1'b1;
                    state_nx  = (post_len == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                wr_now = 1'b1;
                if (post_cnt == ONE) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // abort overrides everything, including a simultaneous arm
        if (abort_i) begin
            state_nx  = ST_IDLE;
            wr_now    = 1'b0;
            arm_take  = 1'b0;
            trig_take = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            post_len     <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            trig_addr_o  <= '0;
            start_addr_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_en_o <= wr_now;
            busy_o  <= (state_nx == ST_PRE) || (state_nx == ST_WAIT) ||
                       (state_nx == ST_POST);
            done_o  <= (state_nx == ST_DONE);

            if (wr_now) begin
                wr_addr_o <= ptr;
                wr_data_o <= {rx_dv_i, rx_d_i};
                ptr       <= ptr + ONE;
            end

            // clamp keeps the post-trigger run from overwriting the history
            if (arm_take) begin
                ptr      <= '0;
                pre_cnt  <= PRE_LAST;
                post_len <= (post_len_i > POST_MAX) ? POST_MAX : post_len_i;
            end else if (wr_now && state == ST_PRE && pre_cnt != '0) begin
                pre_cnt <= pre_cnt - ONE;
            end

            if (trig_take) begin
                trig_addr_o  <= ptr;
                start_addr_o <= ptr - PRE_OFF;
                post_cnt     <= post_len;
            end else if (wr_now && state == ST_POST) begin
                post_cnt <= post_cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// Directed bench for rx_capture_ctrl: a default instance (ADDR_W=11,
// PRE_DEPTH=16) and a small one (ADDR_W=4, PRE_DEPTH=4) for ring wrap.
module tb_rx_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        arm, abort, dv;
    logic [1:0]  mode;
    logic [10:0] post_len;
    logic [7:0]  d;
    logic        wr_en, busy, done;
    logic [10:0] wr_addr, trig_addr, start_addr;
    logic [8:0]  wr_data;

    logic        arm_b, abort_b, dv_b;
    logic [1:0]  mode_b;
    logic [3:0]  post_len_b;
    logic [7:0]  d_b;
    logic        wr_en_b, busy_b, done_b;
    logic [3:0]  wr_addr_b, trig_addr_b, start_addr_b;
    logic [8:0]  wr_data_b;

    int n_chk  = 0;
    int n_pass = 0;
    int nwr;

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       en;
        int         addr;
        int         trig;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[12];

    always #5 clk = ~clk;

    rx_capture_ctrl #(.ADDR_W(11), .PRE_DEPTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm), .abort_i(abort),
        .trig_mode_i(mode), .post_len_i(post_len), .rx_dv_i(dv), .rx_d_i(d),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .trig_addr_o(trig_addr), .start_addr_o(start_addr),
        .busy_o(busy), .done_o(done)
    );

    rx_capture_ctrl #(.ADDR_W(4), .PRE_DEPTH(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm_b), .abort_i(abort_b),
        .trig_mode_i(mode_b), .post_len_i(post_len_b), .rx_dv_i(dv_b), .rx_d_i(d_b),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .trig_addr_o(trig_addr_b), .start_addr_o(start_addr_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // inputs set before the edge; outputs sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pre_fill(input string name);
        for (int i = 0; i < 16; i++) begin
            step();
            chk({name, " pre wr_en"}, int'(wr_en), 1);
            chk({name, " pre addr"}, int'(wr_addr), i);
        end
    endtask

    initial begin
        rst_n = 1'b0; arm = 0; abort = 0; dv = 0; d = 8'h00; mode = 2'b00; post_len = 11'd0;
        arm_b = 0; abort_b = 0; dv_b = 0; d_b = 8'h00; mode_b = 2'b00; post_len_b = 4'd0;
        step(); step();

        // ---- reset state
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        chk("rst wr_data", int'(wr_data), 0);
        chk("rst trig", int'(trig_addr), 0);
        chk("rst start", int'(start_addr), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);

        // ---- test 1: dv rise at ptr 40, post_len 8
        rst_n = 1'b1; mode = 2'b00; post_len = 11'd8; arm = 1; step(); arm = 0;
        chk("t1 arm busy", int'(busy), 1);
        chk("t1 arm wr_en", int'(wr_en), 0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t1 addr", int'(wr_addr), i);
        end
        chk("t1 no trig yet", int'(trig_addr), 0);
        dv = 1; d = 8'h55; step();
        chk("t1 trig wr", int'(wr_addr), 40);
        chk("t1 trig data", int'(wr_data), 9'h155);
        chk("t1 trig addr", int'(trig_addr), 40);
        chk("t1 start addr", int'(start_addr), 24);
        chk("t1 post busy", int'(busy), 1);
        for (int i = 1; i <= 8; i++) begin
            d = 8'(i); step();
            chk("t1 post addr", int'(wr_addr), 40 + i);
            chk("t1 post data", int'(wr_data), 256 + i);
        end
        chk("t1 done", int'(done), 1);
        chk("t1 busy off", int'(busy), 0);
        step();
        chk("t1 wr_en off", int'(wr_en), 0);
        chk("t1 done hold", int'(done), 1);
        chk("t1 trig hold", int'(trig_addr), 40);

        // ---- test 2: SFD mode, second SFD in the frame ignored (table)
        for (int i = 0; i < 7; i++) tv[i] = '{1'b1, 8'h55, 1'b1, 16 + i, 40, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 8'hD5, 1'b1, 23, 23, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 8'h11, 1'b1, 24, 23, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 8'hD5, 1'b1, 25, 23, 1'b1, 1'b0};
        tv[10] = '{1'b1, 8'h22, 1'b1, 26, 23, 1'b0, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b0, 26, 23, 1'b0, 1'b1};
        dv = 0; d = 8'h00; mode = 2'b01; post_len = 11'd3; arm = 1; step(); arm = 0;
        chk("t2 rearm busy", int'(busy), 1);
        chk("t2 rearm done", int'(done), 0);
        pre_fill("t2");
        for (int k = 0; k < 12; k++) begin
            dv = tv[k].dv; d = tv[k].d; step();
            chk("t2 wr_en", int'(wr_en), int'(tv[k].en));
            chk("t2 addr", int'(wr_addr), tv[k].addr);
            if (tv[k].en) chk("t2 data", int'(wr_data), int'({tv[k].dv, tv[k].d}));
            chk("t2 trig", int'(trig_addr), tv[k].trig);
            chk("t2 busy", int'(busy), int'(tv[k].busy));
            chk("t2 done", int'(done), int'(tv[k].done));
        end

        // ---- test 2b: SFD seen during PRE blocks a repeat SFD of the same frame
        post_len = 11'd1; arm = 1; step(); arm = 0;
        for (int i = 0; i < 16; i++) begin
            dv = (i >= 10); d = (i == 12) ? 8'hD5 : 8'h33; step();
        end
        chk("t2b pre trig ignored", int'(trig_addr), 23);
        dv = 1; d = 8'h33; step();
        dv = 1; d = 8'hD5; step();
        chk("t2b repeat sfd addr", int'(wr_addr), 17);
        chk("t2b repeat sfd ignored", int'(trig_addr), 23);
        dv = 0; d = 8'h00; step();
        dv = 1; d = 8'hD5; step();
        chk("t2b new frame trig", int'(trig_addr), 19);
        chk("t2b new frame start", int'(start_addr), 3);
        d = 8'h44; step();
        chk("t2b last addr", int'(wr_addr), 20);
        chk("t2b done", int'(done), 1);

        // ---- test 3: dv rise in PRE ignored, next rise in WAIT triggers
        dv = 0; mode = 2'b00; post_len = 11'd2; arm = 1; step(); arm = 0;
        for (int i = 0; i < 16; i++) begin
            dv = (i >= 3 && i <= 5); d = 8'h66; step();
            if (i == 3) chk("t3 pre rise ignored", int'(trig_addr), 19);
        end
        dv = 0; step(); step();
        chk("t3 wait no trig", int'(trig_addr), 19);
        chk("t3 wait addr", int'(wr_addr), 17);
        dv = 1; step();
        chk("t3 trig", int'(trig_addr), 18);
        chk("t3 start", int'(start_addr), 2);
        step(); step();
        chk("t3 last addr", int'(wr_addr), 20);
        chk("t3 done", int'(done), 1);

        // ---- test 5: abort with arm mid-POST
        dv = 0; mode = 2'b10; post_len = 11'd10; arm = 1; step(); arm = 0;
        pre_fill("t5");
        step();
        chk("t5 imm trig", int'(trig_addr), 16);
        chk("t5 imm start", int'(start_addr), 0);
        step(); step(); step();
        chk("t5 post addr", int'(wr_addr), 19);
        abort = 1; arm = 1; step(); abort = 0; arm = 0;
        chk("t5 abort wr_en", int'(wr_en), 0);
        chk("t5 abort busy", int'(busy), 0);
        chk("t5 abort done", int'(done), 0);
        chk("t5 abort trig hold", int'(trig_addr), 16);
        nwr = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nwr += int'(wr_en) + int'(busy);
        end
        chk("t5 idle after abort", nwr, 0);
        arm = 1; step(); arm = 0;
        chk("t5 restart busy", int'(busy), 1);
        step();
        chk("t5 restart addr0", int'(wr_addr), 0);
        chk("t5 restart wr_en", int'(wr_en), 1);
        abort = 1; step(); abort = 0;
        chk("t5 abort in pre", int'(busy), 0);

        // ---- test 6: post_len 0, immediate; rearm from DONE; reset mid-capture
        post_len = 11'd0; arm = 1; step(); arm = 0;
        pre_fill("t6");
        step();
        chk("t6 single wr", int'(wr_addr), 16);
        chk("t6 trig", int'(trig_addr), 16);
        chk("t6 done", int'(done), 1);
        chk("t6 busy", int'(busy), 0);
        step();
        chk("t6 no more wr", int'(wr_en), 0);
        arm = 1; step(); arm = 0;
        chk("t6 rearm busy", int'(busy), 1);
        chk("t6 rearm done", int'(done), 0);
        step();
        chk("t6 rearm addr0", int'(wr_addr), 0);
        arm = 1; step(); arm = 0;
        chk("t6 arm in pre ignored", int'(wr_addr), 1);
        rst_n = 1'b0; step();
        chk("t6 mid rst wr_en", int'(wr_en), 0);
        chk("t6 mid rst busy", int'(busy), 0);
        chk("t6 mid rst trig", int'(trig_addr), 0);
        chk("t6 mid rst addr", int'(wr_addr), 0);
        rst_n = 1'b1; step();
        chk("t6 idle after rst", int'(busy), 0);

        // ---- test 4: small ring, post_len clamp 15 -> 11, wrap in WAIT
        mode_b = 2'b00; post_len_b = 4'd15; dv_b = 0; arm_b = 1; step(); arm_b = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("t4 ring addr", int'(wr_addr_b), i % 16);
        end
        chk("t4 no early trig", int'(trig_addr_b), 0);
        dv_b = 1; d_b = 8'hA0; step();
        chk("t4 trig", int'(trig_addr_b), 2);
        chk("t4 start", int'(start_addr_b), 14);
        nwr = 1;
        for (int i = 1; i <= 11; i++) begin
            d_b = 8'hA0 + 8'(i); step();
            nwr += int'(wr_en_b);
            chk("t4 post addr", int'(wr_addr_b), (2 + i) % 16);
            chk("t4 post data", int'(wr_data_b), 256 + 160 + i);
        end
        chk("t4 clamped done", int'(done_b), 1);
        step();
        chk("t4 writes after trig", nwr, 12);
        chk("t4 stopped", int'(wr_en_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
